// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, zero-register index and sequencer state encoding.
package regfile_pkg;
   localparam int XLEN = 32;
   localparam int IDXW = 5;
   localparam logic [IDXW-1:0] REG_ZERO = '0;
   typedef enum logic [2:0] {IDLE, RD1, RD2, EXEC, WB} seq_state_t;
endpackage

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: owns the shared register bus; reads rs1/rs2 into operand latches,
// hands them to execute and writes the result back to rd.
module regfile_sequencer
   import regfile_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   inout  wire  [XLEN-1:0] bus,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [IDXW-1:0] rs1,
   input  logic [IDXW-1:0] rs2,
   input  logic            use_rs2,
   input  logic [IDXW-1:0] rd,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   output logic            ops_valid,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_data,
   output logic            wb_ready,
   output logic [IDXW-1:0] reg_idx,
   output logic            reg_en,
   output logic            reg_write
);
   seq_state_t      state_q, state_d;
   logic [IDXW-1:0] rs1_q, rs2_q, rd_q;
   logic            use_rs2_q;
   logic [XLEN-1:0] op_a_q, op_b_q, result_q;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = req_valid ? RD1 : IDLE;
         RD1:     state_d = use_rs2_q ? RD2 : EXEC;
         RD2:     state_d = EXEC;
         EXEC:    state_d = wb_valid ? ((rd_q != REG_ZERO) ? WB : IDLE) : EXEC;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         use_rs2_q <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         result_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid) begin
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            rd_q      <= rd;
            use_rs2_q <= use_rs2;
         end
         if (state_q == RD1) begin
            op_a_q <= bus;
            if (!use_rs2_q) op_b_q <= '0;
         end
         if (state_q == RD2) op_b_q <= bus;
         if (state_q == EXEC && wb_valid) result_q <= wb_data;
      end
   end
   // Every strobe is gated by rst so nothing reaches the register file while reset is held.
   assign req_ready = !rst && state_q == IDLE;
   assign ops_valid = !rst && state_q == EXEC;
   assign wb_ready  = !rst && state_q == EXEC;
   assign reg_en    = !rst && (state_q == RD1 || state_q == RD2);
   assign reg_write = !rst && state_q == WB;
   assign reg_idx   = rst                ? REG_ZERO :
                      (state_q == RD1)   ? rs1_q :
                      (state_q == RD2)   ? rs2_q :
                      (state_q == WB)    ? rd_q  : REG_ZERO;
   assign bus  = reg_write ? result_q : 'z;
   assign op_a = op_a_q;
   assign op_b = op_b_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: sequencer plus a behavioural register file on a shared bus,
// checked against an array model of the expected register contents.
module tb_regfile_sequencer;
   import regfile_pkg::*;
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   wire  [XLEN-1:0] bus;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [IDXW-1:0] rs1 = '0, rs2 = '0, rd = '0;
   logic            use_rs2 = 1'b0;
   logic [XLEN-1:0] op_a, op_b;
   logic            ops_valid;
   logic            wb_valid = 1'b0;
   logic [XLEN-1:0] wb_data = '0;
   logic            wb_ready;
   logic [IDXW-1:0] reg_idx;
   logic            reg_en, reg_write;
   logic [XLEN-1:0] regs [32];
   logic            pre_we = 1'b0;
   logic [IDXW-1:0] pre_idx = '0;
   logic [XLEN-1:0] pre_data = '0;
   logic [XLEN-1:0] mdl [32];
   int n_tests = 0;
   int n_fail = 0;

   regfile_sequencer dut (
      .clk(clk), .rst(rst), .bus(bus),
      .req_valid(req_valid), .req_ready(req_ready),
      .rs1(rs1), .rs2(rs2), .use_rs2(use_rs2), .rd(rd),
      .op_a(op_a), .op_b(op_b), .ops_valid(ops_valid),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready),
      .reg_idx(reg_idx), .reg_en(reg_en), .reg_write(reg_write)
   );

   always #5 clk = ~clk;

   // Register file: combinational read, posedge write, x0 hardwired to zero.
   assign bus = reg_en ? ((reg_idx == 0) ? '0 : regs[reg_idx]) : 'z;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (pre_we) begin
         if (pre_idx != 0) regs[pre_idx] <= pre_data;
      end else if (reg_write && reg_idx != 0) begin
         regs[reg_idx] <= bus;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      n_tests++;
      if (reg_en === 1'b1 && reg_write === 1'b1) begin
         n_fail++;
         $display("FAIL strobe_excl: reg_en=%b reg_write=%b required not both 1", reg_en, reg_write);
      end
      n_tests++;
      if (reg_en !== 1'b1 && reg_write !== 1'b1 && reg_idx !== '0) begin
         n_fail++;
         $display("FAIL idle_idx: reg_idx=%0d required 0 with no strobe", reg_idx);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mdl[i] = '0;
   endtask

   task automatic preload(input logic [IDXW-1:0] idx, input logic [XLEN-1:0] data);
      pre_we = 1'b1; pre_idx = idx; pre_data = data;
      tick();
      pre_we = 1'b0;
      if (idx != 0) mdl[idx] = data;
   endtask

   task automatic run_req(input logic [IDXW-1:0] a, input logic [IDXW-1:0] b, input bit use2,
                          input logic [IDXW-1:0] d, input logic [XLEN-1:0] data,
                          input int stall, input bit poke);
      logic [XLEN-1:0] exp_a, exp_b;
      bit ok;
      int n;
      exp_a = mdl[a];
      exp_b = use2 ? mdl[b] : '0;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_timeout: req_ready=%b required 1 within 20 cycles", req_ready);
      end
      rs1 = a; rs2 = b; use_rs2 = use2; rd = d; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      rs1 = IDXW'($urandom); rs2 = IDXW'($urandom); rd = IDXW'($urandom); use_rs2 = ~use2;
      n_tests++;
      if (!(reg_en === 1'b1 && reg_write === 1'b0 && reg_idx === a && bus === exp_a &&
            ops_valid === 1'b0 && req_ready === 1'b0)) begin
         n_fail++;
         $display("FAIL rd1: en=%b idx=%0d bus=%h ops_valid=%b required en=1 idx=%0d bus=%h ops_valid=0",
                  reg_en, reg_idx, bus, ops_valid, a, exp_a);
      end
      if (use2) begin
         tick();
         n_tests++;
         if (!(reg_en === 1'b1 && reg_write === 1'b0 && reg_idx === b && bus === exp_b && ops_valid === 1'b0)) begin
            n_fail++;
            $display("FAIL rd2: en=%b idx=%0d bus=%h ops_valid=%b required en=1 idx=%0d bus=%h ops_valid=0",
                     reg_en, reg_idx, bus, ops_valid, b, exp_b);
         end
      end
      tick();
      n_tests++;
      if (!(ops_valid === 1'b1 && wb_ready === 1'b1 && op_a === exp_a && op_b === exp_b &&
            reg_en === 1'b0 && reg_write === 1'b0)) begin
         n_fail++;
         $display("FAIL exec: ops_valid=%b wb_ready=%b op_a=%h op_b=%h required 1 1 %h %h",
                  ops_valid, wb_ready, op_a, op_b, exp_a, exp_b);
      end
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
         if (poke) begin
            req_valid = 1'b1; rs1 = IDXW'($urandom); rs2 = IDXW'($urandom); rd = IDXW'($urandom);
         end
         tick();
         req_valid = 1'b0;
         ok &= (ops_valid === 1'b1 && req_ready === 1'b0 && reg_en === 1'b0 && reg_write === 1'b0 &&
                op_a === exp_a && op_b === exp_b);
      end
      if (stall > 0) begin
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL stall: ops_valid=%b req_ready=%b en=%b wr=%b required 1 0 0 0 for %0d cycles",
                     ops_valid, req_ready, reg_en, reg_write, stall);
         end
      end
      wb_valid = 1'b1; wb_data = data;
      tick();
      wb_valid = 1'b0; wb_data = $urandom;
      if (d != 0) begin
         n_tests++;
         if (!(reg_write === 1'b1 && reg_en === 1'b0 && reg_idx === d && bus === data && ops_valid === 1'b0)) begin
            n_fail++;
            $display("FAIL wb: wr=%b en=%b idx=%0d bus=%h required wr=1 en=0 idx=%0d bus=%h",
                     reg_write, reg_en, reg_idx, bus, d, data);
         end
         tick();
         mdl[d] = data;
         n_tests++;
         if (!(req_ready === 1'b1 && regs[d] === mdl[d])) begin
            n_fail++;
            $display("FAIL wb_land: ready=%b x%0d=%h required ready=1 value %h", req_ready, d, regs[d], mdl[d]);
         end
      end else begin
         n_tests++;
         if (!(reg_write === 1'b0 && req_ready === 1'b1 && regs[0] === '0)) begin
            n_fail++;
            $display("FAIL rd_zero: wr=%b ready=%b x0=%h required wr=0 ready=1 x0=0", reg_write, req_ready, regs[0]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_tests++;
      if (!(req_ready === 1'b0 && reg_en === 1'b0 && reg_write === 1'b0 && ops_valid === 1'b0)) begin
         n_fail++;
         $display("FAIL reset_hold: ready=%b en=%b wr=%b ops_valid=%b required all 0", req_ready, reg_en, reg_write, ops_valid);
      end
      rst = 1'b0;
      clear_model();
      #1;
      n_tests++;
      if (!(req_ready === 1'b1 && ops_valid === 1'b0 && wb_ready === 1'b0 && op_a === '0 && op_b === '0)) begin
         n_fail++;
         $display("FAIL reset_out: ready=%b ops_valid=%b wb_ready=%b op_a=%h op_b=%h required 1 0 0 0 0",
                  req_ready, ops_valid, wb_ready, op_a, op_b);
      end
   endtask

   task automatic test_two_operand();
      preload(5'd3, 32'h1111_1111);
      preload(5'd4, 32'h2222_2222);
      run_req(5'd3, 5'd4, 1'b1, 5'd5, 32'h3333_3333, 0, 1'b0);
   endtask

   task automatic test_single_operand();
      run_req(5'd5, 5'd4, 1'b0, 5'd6, $urandom, 1, 1'b0);
   endtask

   task automatic test_rd_zero();
      run_req(5'd3, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 0, 1'b0);
      run_req(5'd0, 5'd0, 1'b1, 5'd8, 32'h0BAD_F00D, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_req(5'd4, 5'd3, 1'b1, 5'd9, 32'h5A5A_A5A5, 10, 1'b1);
   endtask

   task automatic test_reset_in_wb();
      run_req(5'd9, 5'd0, 1'b0, 5'd1, 32'h0000_0001, 0, 1'b0);
      rs1 = 5'd3; rs2 = 5'd4; use_rs2 = 1'b1; rd = 5'd7; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (2) tick();
      wb_valid = 1'b1; wb_data = 32'hAAAA_5555;
      tick();
      wb_valid = 1'b0;
      n_tests++;
      if (reg_write !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_rst_wb: reg_write=%b required 1", reg_write);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (!(reg_write === 1'b0 && reg_en === 1'b0 && req_ready === 1'b0 && reg_idx === '0)) begin
         n_fail++;
         $display("FAIL rst_in_wb: wr=%b en=%b ready=%b idx=%0d required 0 0 0 0", reg_write, reg_en, req_ready, reg_idx);
      end
      tick();
      rst = 1'b0;
      clear_model();
      #1;
      n_tests++;
      if (!(req_ready === 1'b1 && ops_valid === 1'b0 && op_a === '0 && op_b === '0 && regs[7] === '0)) begin
         n_fail++;
         $display("FAIL post_rst: ready=%b ops_valid=%b op_a=%h op_b=%h x7=%h required 1 0 0 0 0",
                  req_ready, ops_valid, op_a, op_b, regs[7]);
      end
   endtask

   task automatic test_random();
      for (int i = 1; i < 32; i++) preload(IDXW'(i), $urandom);
      for (int k = 0; k < 40; k++)
         run_req(IDXW'($urandom), IDXW'($urandom), 1'($urandom), IDXW'($urandom), $urandom,
                 int'($urandom_range(0, 3)), 1'($urandom));
      n_tests++;
      begin
         int bad = 0;
         for (int i = 0; i < 32; i++) if (regs[i] !== mdl[i]) bad++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL regfile_final: %0d registers differ, required 0", bad);
         end
      end
   endtask

   initial begin
      clear_model();
      test_reset();
      test_two_operand();
      test_single_operand();
      test_rd_zero();
      test_stall();
      test_reset_in_wb();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
